// File: rtl/traffic_light_fsm.sv
`default_nettype none
// traffic_light_fsm: NS/EW intersection controller with a pedestrian walk phase,
// timed by rising edges of the divider's clk1hz sampled as data in the clk100 domain.

package traffic_light_fsm_pkg;
  typedef enum logic [2:0] {
    ST_NS_GREEN  = 3'd0,
    ST_NS_YELLOW = 3'd1,
    ST_ALLRED_A  = 3'd2,
    ST_EW_GREEN  = 3'd3,
    ST_EW_YELLOW = 3'd4,
    ST_ALLRED_B  = 3'd5,
    ST_PED_WALK  = 3'd6,
    ST_ILLEGAL   = 3'd7
  } state_t;
endpackage

module traffic_light_fsm
  import traffic_light_fsm_pkg::*;
#(
  parameter int GREEN_T  = 5,
  parameter int YELLOW_T = 2,
  parameter int ALLRED_T = 1,
  parameter int WALK_T   = 4
) (
  input  logic       clk100,
  input  logic       reset,
  input  logic       clk1hz,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] state_o,
  output logic [7:0] sec_left
);

  // A zero duration would never expire cleanly, so it is promoted to one tick.
  localparam logic [7:0] c_green_ticks  = (GREEN_T  < 1) ? 8'd1 : 8'(GREEN_T);
  localparam logic [7:0] c_yellow_ticks = (YELLOW_T < 1) ? 8'd1 : 8'(YELLOW_T);
  localparam logic [7:0] c_allred_ticks = (ALLRED_T < 1) ? 8'd1 : 8'(ALLRED_T);
  localparam logic [7:0] c_walk_ticks   = (WALK_T   < 1) ? 8'd1 : 8'(WALK_T);
  localparam logic       c_dir_ns       = 1'b0;
  localparam logic       c_dir_ew       = 1'b1;

  state_t     state_q,       state_d;
  logic [7:0] sec_left_q,    sec_left_d;
  logic       ped_pending_q, ped_pending_d;
  logic       next_dir_q,    next_dir_d;
  logic [2:0] ns_light_q,    ns_light_d;
  logic [2:0] ew_light_q,    ew_light_d;
  logic       walk_q,        walk_d;
  logic       clk1hz_q;
  logic       tick;
  logic       ped_now;

  function automatic logic [7:0] f_duration(input state_t s);
    case (s)
      ST_NS_YELLOW, ST_EW_YELLOW: f_duration = c_yellow_ticks;
      ST_ALLRED_A,  ST_ALLRED_B:  f_duration = c_allred_ticks;
      ST_PED_WALK:                f_duration = c_walk_ticks;
      default:                    f_duration = c_green_ticks;
    endcase
  endfunction

  function automatic logic [2:0] f_lamp(input logic is_green, input logic is_yellow);
    if (is_green)       f_lamp = 3'b001;
    else if (is_yellow) f_lamp = 3'b010;
    else                f_lamp = 3'b100;
  endfunction

  assign tick = clk1hz & ~clk1hz_q;

  always_comb begin
    state_d       = state_q;
    sec_left_d    = sec_left_q;
    next_dir_d    = next_dir_q;
    // A request arriving on the expiry cycle itself is still served at that expiry.
    ped_now       = ped_pending_q | (ped_req && (state_q != ST_PED_WALK));
    ped_pending_d = ped_now;

    if (state_q == ST_ILLEGAL) begin
      state_d    = ST_NS_GREEN;
      sec_left_d = c_green_ticks;
    end else if (tick) begin
      if (sec_left_q > 8'd1) begin
        sec_left_d = sec_left_q - 8'd1;
      end else begin
        case (state_q)
          ST_NS_GREEN:  state_d = ST_NS_YELLOW;
          ST_NS_YELLOW: state_d = ST_ALLRED_A;
          ST_ALLRED_A: begin
            if (ped_now) begin
              state_d    = ST_PED_WALK;
              next_dir_d = c_dir_ew;
            end else begin
              state_d    = ST_EW_GREEN;
            end
          end
          ST_EW_GREEN:  state_d = ST_EW_YELLOW;
          ST_EW_YELLOW: state_d = ST_ALLRED_B;
          ST_ALLRED_B: begin
            if (ped_now) begin
              state_d    = ST_PED_WALK;
              next_dir_d = c_dir_ns;
            end else begin
              state_d    = ST_NS_GREEN;
            end
          end
          ST_PED_WALK:  state_d = (next_dir_q == c_dir_ew) ? ST_EW_GREEN : ST_NS_GREEN;
          default:      state_d = ST_NS_GREEN;
        endcase
        sec_left_d = f_duration(state_d);
      end
    end

    if ((state_d == ST_PED_WALK) && (state_q != ST_PED_WALK)) begin
      ped_pending_d = 1'b0;
    end

    ns_light_d = f_lamp(state_d == ST_NS_GREEN, state_d == ST_NS_YELLOW);
    ew_light_d = f_lamp(state_d == ST_EW_GREEN, state_d == ST_EW_YELLOW);
    walk_d     = (state_d == ST_PED_WALK);
  end

  // clk1hz_q resets high so a clk1hz already high at reset release is not a tick.
  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      clk1hz_q      <= 1'b1;
      state_q       <= ST_NS_GREEN;
      sec_left_q    <= c_green_ticks;
      ped_pending_q <= 1'b0;
      next_dir_q    <= c_dir_ew;
      ns_light_q    <= 3'b001;
      ew_light_q    <= 3'b100;
      walk_q        <= 1'b0;
    end else begin
      clk1hz_q      <= clk1hz;
      state_q       <= state_d;
      sec_left_q    <= sec_left_d;
      ped_pending_q <= ped_pending_d;
      next_dir_q    <= next_dir_d;
      ns_light_q    <= ns_light_d;
      ew_light_q    <= ew_light_d;
      walk_q        <= walk_d;
    end
  end

  assign ns_light = ns_light_q;
  assign ew_light = ew_light_q;
  assign walk     = walk_q;
  assign state_o  = state_q;
  assign sec_left = sec_left_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_light_fsm.sv
`default_nettype none
// tb_traffic_light_fsm: directed stimulus; a reference model pushes expected
// observations into a queue that is popped and asserted once the DUT has responded.

module tb_traffic_light_fsm;
  import traffic_light_fsm_pkg::*;

  logic       clk100 = 1'b0;
  logic       reset;
  logic       clk1hz;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic [2:0] state_o;
  logic [7:0] sec_left;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [17:0] exp;
  } exp_t;
  exp_t sbq[$];

  int m_state;
  int m_sec;
  bit m_pend;
  bit m_dir_ew;

  always #5 clk100 = ~clk100;

  traffic_light_fsm dut (
    .clk100   (clk100),
    .reset    (reset),
    .clk1hz   (clk1hz),
    .ped_req  (ped_req),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .walk     (walk),
    .state_o  (state_o),
    .sec_left (sec_left)
  );

  function automatic int dur(input int s);
    case (s)
      0, 3:    return 5;
      1, 4:    return 2;
      2, 5:    return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [17:0] expect_vec(input int s, input int sec);
    logic [2:0] ns;
    logic [2:0] ew;
    ns = (s == 0) ? 3'b001 : (s == 1) ? 3'b010 : 3'b100;
    ew = (s == 3) ? 3'b001 : (s == 4) ? 3'b010 : 3'b100;
    return {3'(s), 8'(sec), ns, ew, (s == 6)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_sec    = 5;
    m_pend   = 1'b0;
    m_dir_ew = 1'b1;
  endtask

  task automatic model_go(input int s);
    m_state = s;
    m_sec   = dur(s);
    if (s == 6) m_pend = 1'b0;
  endtask

  task automatic model_tick();
    if (m_sec > 1) begin
      m_sec--;
    end else begin
      case (m_state)
        0: model_go(1);
        1: model_go(2);
        2: if (m_pend) begin m_dir_ew = 1'b1; model_go(6); end else model_go(3);
        3: model_go(4);
        4: model_go(5);
        5: if (m_pend) begin m_dir_ew = 1'b0; model_go(6); end else model_go(0);
        default: model_go(m_dir_ew ? 3 : 0);
      endcase
    end
  endtask

  task automatic push(input string tag);
    sbq.push_back('{tag, expect_vec(m_state, m_sec)});
  endtask

  task automatic pop_check();
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed=0 entries expected=1");
    end else begin
      e = sbq.pop_front();
      check(e.tag, {14'd0, state_o, sec_left, ns_light, ew_light, walk}, {14'd0, e.exp});
    end
  endtask

  task automatic tick(input string tag, input bit ped_on_tick);
    @(negedge clk100);
    if (ped_req && m_state != 6) m_pend = 1'b1;
    clk1hz = 1'b1;
    if (ped_on_tick) begin
      ped_req = 1'b1;
      if (m_state != 6) m_pend = 1'b1;
    end
    model_tick();
    push(tag);
    @(negedge clk100);
    clk1hz = 1'b0;
    if (ped_on_tick) ped_req = 1'b0;
    pop_check();
    check({tag, "_noconflict"}, {31'd0, (ns_light != 3'b100) && (ew_light != 3'b100)}, 32'd0);
  endtask

  task automatic pulse_ped();
    @(negedge clk100);
    ped_req = 1'b1;
    if (m_state != 6) m_pend = 1'b1;
    @(negedge clk100);
    ped_req = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    clk1hz  = 1'b0;
    ped_req = 1'b0;
    model_reset();
    repeat (3) @(negedge clk100);
    push("reset_state");
    pop_check();
    reset = 1'b0;

    for (int i = 0; i < 16; i++) tick("t1_cycle", 1'b0);

    pulse_ped();
    for (int i = 0; i < 8; i++) tick("t2_to_walk", 1'b0);
    check("t2_pend_clr", {31'd0, dut.ped_pending_q}, 32'd0);
    pulse_ped();
    for (int i = 0; i < 12; i++) tick("t2_walk_exit", 1'b0);
    check("t2_walk_req_ignored", {31'd0, dut.ped_pending_q}, 32'd0);

    @(negedge clk100);
    ped_req = 1'b1;
    for (int i = 0; i < 24; i++) tick("t3_held_req", 1'b0);
    ped_req = 1'b0;
    for (int i = 0; i < 8; i++) tick("t3_no_requeue", 1'b0);

    for (int i = 0; i < 7; i++) tick("t3b_to_allred_b", 1'b0);
    tick("t3b_late_req", 1'b1);
    for (int i = 0; i < 4; i++) tick("t3b_walk_to_ns", 1'b0);

    @(negedge clk100);
    clk1hz = 1'b1;
    model_tick();
    push("t4_held_high");
    repeat (500) @(negedge clk100);
    pop_check();
    clk1hz = 1'b0;
    repeat (3) @(negedge clk100);
    push("t4_after_low");
    pop_check();

    for (int i = 0; i < 40 && m_state != 4; i++) tick("t5_to_ew_yellow", 1'b0);
    tick("t5_mid_yellow", 1'b0);
    @(negedge clk100);
    #2;
    clk1hz = 1'b1;
    reset  = 1'b1;
    #1;
    model_reset();
    push("t5_async_reset");
    pop_check();
    @(negedge clk100);
    reset = 1'b0;
    @(negedge clk100);
    push("t5_no_tick_after_reset");
    pop_check();
    @(negedge clk100);
    push("t5_still_no_tick");
    pop_check();
    clk1hz = 1'b0;

    tick("t6_pre", 1'b0);
    tick("t6_pre", 1'b0);
    @(negedge clk100);
    force dut.state_q = ST_ILLEGAL;
    #1;
    check("t6_forced", {29'd0, state_o}, 32'd7);
    release dut.state_q;
    m_state = 0;
    m_sec   = 5;
    @(negedge clk100);
    push("t6_illegal_recover");
    pop_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
